// File: rtl/nn_loader_pkg.sv
// Shared definitions for the neuron configuration loader: FSM states and
// the bit positions of the per-record header fields.
package nn_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_WGT  = 3'd2,
    ST_BIAS = 3'd3,
    ST_SKIP = 3'd4
  } state_e;

  localparam int LAYER_MSB  = 31;
  localparam int LAYER_LSB  = 24;
  localparam int NEURON_MSB = 23;
  localparam int NEURON_LSB = 16;
  localparam int CNT_MSB    = 15;
  localparam int CNT_LSB    = 0;

endpackage

// File: rtl/nn_weight_loader.sv
// Parses a stream of {header, weights, bias} neuron records and drives the
// broadcast configuration bus snooped by every neuron of the network.
module nn_weight_loader
  import nn_loader_pkg::*;
#(
  parameter int NUM_RECORDS = 30,
  parameter int MAX_WEIGHTS = 784,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             weightValid,
  output logic [31:0]      weightValue,
  output logic             biasValid,
  output logic [31:0]      biasValue,
  output logic [31:0]      config_layer_num,
  output logic [31:0]      config_neuron_num,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] neuron_count
);

  localparam int LAYER_W  = LAYER_MSB - LAYER_LSB + 1;
  localparam int NEURON_W = NEURON_MSB - NEURON_LSB + 1;
  localparam logic [CNT_W:0]   MAX_N    = (CNT_W+1)'(MAX_WEIGHTS);
  localparam logic [CNT_W-1:0] LAST_REC = CNT_W'(NUM_RECORDS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  // One bit wider than the header count so N+1 (weights plus bias) never wraps.
  logic [CNT_W:0]        skip_q, skip_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wvld_q, wvld_d;
  logic                  bvld_q, bvld_d;
  logic [31:0]           wval_q, wval_d;
  logic [31:0]           bval_q, bval_d;
  logic [LAYER_W-1:0]    layer_q, layer_d;
  logic [NEURON_W-1:0]   neuron_q, neuron_d;

  logic                  hs;
  logic                  rec_end;
  logic [CNT_W-1:0]      hdr_n;

  assign s_ready = (state_q != ST_IDLE) && !start;
  assign hs      = s_valid && s_ready;
  assign hdr_n   = CNT_W'(s_data[CNT_MSB:CNT_LSB]);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    skip_d   = skip_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    wvld_d   = 1'b0;
    bvld_d   = 1'b0;
    wval_d   = wval_q;
    bval_d   = bval_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    rec_end  = 1'b0;

    if (start) begin
      state_d = ST_HDR;
      wcnt_d  = '0;
      skip_d  = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_HDR: if (hs) begin
          if ({1'b0, hdr_n} > MAX_N) begin
            err_d   = 1'b1;
            skip_d  = {1'b0, hdr_n} + (CNT_W+1)'(1);
            state_d = ST_SKIP;
          end else begin
            layer_d  = s_data[LAYER_MSB:LAYER_LSB];
            neuron_d = s_data[NEURON_MSB:NEURON_LSB];
            wcnt_d   = hdr_n;
            state_d  = (hdr_n == '0) ? ST_BIAS : ST_WGT;
          end
        end
        ST_WGT: if (hs) begin
          wval_d = s_data;
          wvld_d = 1'b1;
          wcnt_d = wcnt_q - CNT_W'(1);
          if (wcnt_q == CNT_W'(1)) state_d = ST_BIAS;
        end
        ST_BIAS: if (hs) begin
          bval_d  = s_data;
          bvld_d  = 1'b1;
          rec_end = 1'b1;
        end
        ST_SKIP: if (hs) begin
          skip_d = skip_q - (CNT_W+1)'(1);
          if (skip_q == (CNT_W+1)'(1)) rec_end = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      // Completed and discarded records share the same end-of-session test.
      if (rec_end) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_REC) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_HDR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      skip_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wvld_q   <= 1'b0;
      bvld_q   <= 1'b0;
      wval_q   <= '0;
      bval_q   <= '0;
      layer_q  <= '0;
      neuron_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      skip_q   <= skip_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wvld_q   <= wvld_d;
      bvld_q   <= bvld_d;
      wval_q   <= wval_d;
      bval_q   <= bval_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
    end
  end

  assign weightValid       = wvld_q;
  assign weightValue       = wval_q;
  assign biasValid         = bvld_q;
  assign biasValue         = bval_q;
  assign config_layer_num  = {{(32-LAYER_W){1'b0}}, layer_q};
  assign config_neuron_num = {{(32-NEURON_W){1'b0}}, neuron_q};
  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign err               = err_q;
  assign neuron_count      = cnt_q;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Bench for nn_weight_loader: one-record and two-record instances, table-driven
// record sessions plus hand-written discard, abort and reset sequences.
module tb_nn_weight_loader;

  localparam int MAXW = 784;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic sel = 1'b0;

  logic [1:0]       rdy_v, wv_v, bv_v, busy_v, done_v, err_v;
  logic [1:0][31:0] wval_v, bval_v, lay_v, neu_v;
  logic [1:0][15:0] cnt_v;

  logic        rdy, wv, bv, busy, done, err;
  logic [31:0] wval, bval, lay, neu;
  logic [15:0] cnt;

  assign rdy  = rdy_v[sel];
  assign wv   = wv_v[sel];
  assign bv   = bv_v[sel];
  assign busy = busy_v[sel];
  assign done = done_v[sel];
  assign err  = err_v[sel];
  assign wval = wval_v[sel];
  assign bval = bval_v[sel];
  assign lay  = lay_v[sel];
  assign neu  = neu_v[sel];
  assign cnt  = cnt_v[sel];

  nn_weight_loader #(.NUM_RECORDS(1), .MAX_WEIGHTS(MAXW), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(rdy_v[0]),
    .s_data(s_data), .weightValid(wv_v[0]), .weightValue(wval_v[0]),
    .biasValid(bv_v[0]), .biasValue(bval_v[0]), .config_layer_num(lay_v[0]),
    .config_neuron_num(neu_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .err(err_v[0]), .neuron_count(cnt_v[0])
  );

  nn_weight_loader #(.NUM_RECORDS(2), .MAX_WEIGHTS(MAXW), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(rdy_v[1]),
    .s_data(s_data), .weightValid(wv_v[1]), .weightValue(wval_v[1]),
    .biasValid(bv_v[1]), .biasValue(bval_v[1]), .config_layer_num(lay_v[1]),
    .config_neuron_num(neu_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .err(err_v[1]), .neuron_count(cnt_v[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 1 = weight strobe, 2 = bias strobe
    logic [31:0] val;
    int          stamp;  // negedge count at the accepting posedge
  } exp_t;

  typedef struct {
    logic [31:0] hdr;
    int          nw;
    logic [31:0] wbase;
    logic [31:0] bias;
    int          gap;
    logic [31:0] exp_lay;
    logic [31:0] exp_neu;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest accepted weight/bias word,
  // one cycle after its handshake.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (wv === 1'b1 || bv === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: wv=%b bv=%b expected no strobe (t=%0t)", wv, bv, $time);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_overlap", {31'b0, wv & bv}, 32'd0);
        chk("strobe_kind", (wv === 1'b1) ? 32'd1 : 32'd2, e.kind);
        chk("strobe_value", (wv === 1'b1) ? wval : bval, e.val);
        chk("strobe_latency", ncyc, e.stamp + 1);
      end
    end
  end

  task automatic send(input logic [31:0] d, input int kind, input int gap);
    int   n;
    logic got;
    exp_t e;
    n = 0;
    got = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    while (1) begin
      #1 got = rdy;
      @(posedge clk);
      if (got) break;
      n++;
      if (n >= 64) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word 0x%0h not accepted within %0d cycles", d, n);
        break;
      end
      @(negedge clk);
    end
    if (got && kind != 0) begin
      e.kind = kind;
      e.val = d;
      e.stamp = ncyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    s_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_ready"}, {31'b0, rdy}, 32'd0);
    chk({tag, "_weightValid"}, {31'b0, wv}, 32'd0);
    chk({tag, "_biasValid"}, {31'b0, bv}, 32'd0);
    chk({tag, "_weightValue"}, wval, 32'd0);
    chk({tag, "_biasValue"}, bval, 32'd0);
    chk({tag, "_layer"}, lay, 32'd0);
    chk({tag, "_neuron"}, neu, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_count"}, {16'b0, cnt}, 32'd0);
  endtask

  task automatic send_discard();
    send({8'h03, 8'h07, 16'(MAXW + 1)}, 0, 0);
    for (int i = 0; i < MAXW + 2; i++) send(32'(i) ^ 32'h5A5A_0000, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{32'h0401_0003, 3, 32'h0000_000A, 32'h0000_DEA9, 0, 32'd4, 32'd1};
    tbl[1] = '{32'h0401_0003, 3, 32'h0000_000A, 32'h0000_DEA9, 2, 32'd4, 32'd1};
    tbl[2] = '{32'h0205_0000, 0, 32'h0000_0000, 32'h0000_1234, 0, 32'd2, 32'd5};
    tbl[3] = '{32'hFF80_0002, 2, 32'hFFFF_FFFE, 32'h8000_0000, 1, 32'd255, 32'd128};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    sel = 1'b0;
    #1 chk_zero("reset1");
    sel = 1'b1;
    #1 chk_zero("reset2");

    // One-record sessions on the NUM_RECORDS=1 instance
    sel = 1'b0;
    for (int v = 0; v < 4; v++) begin
      pulse_start();
      #1;
      chk("sess_start_done_clr", {31'b0, done}, 32'd0);
      chk("sess_start_busy", {31'b0, busy}, 32'd1);
      send(tbl[v].hdr, 0, 0);
      for (int i = 0; i < tbl[v].nw; i++) send(tbl[v].wbase + 32'(i), 1, tbl[v].gap);
      send(tbl[v].bias, 2, tbl[v].gap);
      idle();
      @(negedge clk);
      #1;
      chk("sess_layer", lay, tbl[v].exp_lay);
      chk("sess_neuron", neu, tbl[v].exp_neu);
      chk("sess_done", {31'b0, done}, 32'd1);
      chk("sess_count", {16'b0, cnt}, 32'd1);
      chk("sess_err", {31'b0, err}, 32'd0);
      chk("sess_busy", {31'b0, busy}, 32'd0);
      chk("sess_ready_idle", {31'b0, rdy}, 32'd0);
      chk("sess_pending", exp_q.size(), 32'd0);
    end

    // Oversized record is discarded, the following record loads normally
    sel = 1'b1;
    do_reset();
    pulse_start();
    send_discard();
    idle();
    #1;
    chk("skip_err", {31'b0, err}, 32'd1);
    chk("skip_count", {16'b0, cnt}, 32'd1);
    chk("skip_done", {31'b0, done}, 32'd0);
    chk("skip_busy", {31'b0, busy}, 32'd1);
    chk("skip_layer_kept", lay, 32'd0);
    chk("skip_neuron_kept", neu, 32'd0);
    send(32'h0102_0001, 0, 0);
    send(32'h0000_0055, 1, 0);
    send(32'h0000_0066, 2, 0);
    idle();
    @(negedge clk);
    #1;
    chk("skip2_layer", lay, 32'd1);
    chk("skip2_neuron", neu, 32'd2);
    chk("skip2_count", {16'b0, cnt}, 32'd2);
    chk("skip2_done", {31'b0, done}, 32'd1);
    chk("skip2_err", {31'b0, err}, 32'd1);
    chk("skip2_pending", exp_q.size(), 32'd0);

    // Abort mid-record after a discard: start clears err and the count
    pulse_start();
    send_discard();
    send(32'h0401_0003, 0, 0);
    send(32'h0000_000A, 1, 0);
    send(32'h0000_000B, 1, 0);
    @(negedge clk);
    start = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h0000_000C;
    #1 chk("abort_ready", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("abort_count", {16'b0, cnt}, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd1);
    chk("abort_layer_kept", lay, 32'd4);
    chk("abort_neuron_kept", neu, 32'd1);
    send(32'h0909_0001, 0, 0);
    send(32'h0000_0077, 1, 0);
    send(32'h0000_0088, 2, 0);
    idle();
    @(negedge clk);
    #1;
    chk("abort2_layer", lay, 32'd9);
    chk("abort2_neuron", neu, 32'd9);
    chk("abort2_count", {16'b0, cnt}, 32'd1);
    chk("abort2_done", {31'b0, done}, 32'd0);
    chk("abort2_err", {31'b0, err}, 32'd0);
    chk("abort2_pending", exp_q.size(), 32'd0);

    // Reset in the cycle a weight is accepted
    sel = 1'b0;
    pulse_start();
    send(32'h0401_0003, 0, 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 32'h0000_000A;
    rst = 1'b1;
    #1 chk("rst_hs_ready", {31'b0, rdy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_ready", {31'b0, rdy}, 32'd0);
      chk("rst_hold_busy", {31'b0, busy}, 32'd0);
    end
    s_valid = 1'b0;
    pulse_start();
    #1 chk("rst_restart_ready", {31'b0, rdy}, 32'd1);
    chk("rst_pending", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
